ex_mem_reg: RTL

//  EX/MEM pipeline register of the 5-stage mini RISC-V core; sits directly downstream of the ID/EX register and EX ALU.

---
 rtl/ex_mem_reg.sv | 93 +++++++++
 1 files changed

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: captures EX results and control with stall/flush/valid,
// and produces MEM-stage forwarding data, hit flags and load-use detection toward ID.
module ex_mem_reg #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             cnt_clr,
    input  logic             valid_i,
    input  logic [1:0]       wd_sel_i,
    input  logic             rf_we_i,
    input  logic             dram_we_i,
    input  logic [31:0]      alu_c_i,
    input  logic [31:0]      rd2_i,
    input  logic [31:0]      wD_i,
    input  logic [4:0]       wR_i,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    output logic             valid_o,
    output logic [1:0]       wd_sel_o,
    output logic             rf_we_o,
    output logic             dram_we_o,
    output logic [31:0]      alu_c_o,
    output logic [31:0]      rd2_o,
    output logic [31:0]      wD_o,
    output logic [4:0]       wR_o,
    output logic [31:0]      fwd_val_o,
    output logic             fwd1_hit,
    output logic             fwd2_hit,
    output logic             load_use,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_DRAM = 2'd1;
    localparam logic [1:0] WD_WD   = 2'd2;
    localparam logic [1:0] WD_RSVD = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Pipeline registers. Priority: rst > flush > stall > load.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_o   <= 1'b0;
            wd_sel_o  <= WD_ALU;
            rf_we_o   <= 1'b0;
            dram_we_o <= 1'b0;
            alu_c_o   <= '0;
            rd2_o     <= '0;
            wD_o      <= '0;
            wR_o      <= '0;
        end else if (!stall) begin
            valid_o   <= valid_i;
            wd_sel_o  <= wd_sel_i;
            rf_we_o   <= rf_we_i & valid_i;
            dram_we_o <= dram_we_i & valid_i;
            alu_c_o   <= alu_c_i;
            rd2_o     <= rd2_i;
            wD_o      <= wD_i;
            wR_o      <= wR_i;
        end
    end

    // Saturating debug counters; a clear takes precedence over an increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (flush && (flush_cnt != CNT_MAX))
                flush_cnt <= flush_cnt + 1'b1;
            if (stall && !flush && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    logic [1:0] wd_eff;
    logic       writes_rd;

    // The reserved writeback encoding behaves as an ALU result downstream.
    always_comb begin
        wd_eff    = (wd_sel_o == WD_RSVD) ? WD_ALU : wd_sel_o;
        writes_rd = valid_o & rf_we_o & (wR_o != 5'd0);
        fwd_val_o = (wd_eff == WD_WD) ? wD_o : alu_c_o;
        fwd1_hit  = writes_rd & (wR_o == id_rs1) & (wd_eff != WD_DRAM);
        fwd2_hit  = writes_rd & (wR_o == id_rs2) & (wd_eff != WD_DRAM);
        load_use  = writes_rd & (wd_eff == WD_DRAM) & ((wR_o == id_rs1) | (wR_o == id_rs2));
    end

endmodule
